mure_retire_scheduler: RTL and testbench

MURE_RETIRE_SCHEDULER -- requirements
Module: mure_retire_scheduler

---
 rtl/mure_retire_scheduler.sv | 150 +++++++++++++++
 tb/tb_mure_retire_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mure_retire_scheduler.sv
// -----------------------------------------------------------------------------
// mure_retire_scheduler
//
// Serialises one retirement group (up to NRET commit-port slots) from the
// head of the ingress FIFOs onto a single-slot trace-encoder interface.
// Valid slots are presented lowest index first. The final valid slot is
// flagged with last_o. The FIFO head is popped on that slot's handshake.
// An empty group, or a flush, pops the head without presenting anything.
//
// Optional feature (macro MURE_SCHED_STALL_CNT_EN):
//   When the macro is defined, a 16-bit saturating counter is built. It counts
//   the cycles in which a slot is presented but not accepted. When the macro
//   is undefined, stall_cnt_o is tied to zero and no counter register exists.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   group_valid_i  FIFO head holds a retirement group
//   slot_mask_i    per-slot valid bits of the head group
//   pop_o          pop one group from the ingress FIFOs this cycle
//   flush_i        synchronous abort of the current group
//   out_valid_o    a slot is presented to the trace encoder
//   out_ready_i    trace encoder accepts the presented slot
//   sel_o          slot index driving the retirement datapath output mux
//   last_o         presented slot is the final valid slot of its group
//   stall_cnt_o    saturating count of stalled presentation cycles
// -----------------------------------------------------------------------------

package mure_pkg;
  localparam int NRET = 2;
endpackage

module mure_retire_scheduler #(
  parameter int NRET  = mure_pkg::NRET,
  parameter int IDX_W = $clog2(NRET)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              group_valid_i,
  input  logic [NRET-1:0]   slot_mask_i,
  output logic              pop_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  sel_o,
  output logic              last_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NRET-1:0] rem_q, rem_d;     // slots of the latched group not yet accepted
  logic [IDX_W-1:0] low_idx;
  logic            emit;
  logic            is_last;
  logic            pop_raw;

  // Lowest set bit of the remaining mask. The loop scans downward, so the
  // last match found is the lowest index.
  always_comb begin
    low_idx = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (rem_q[i]) low_idx = IDX_W'(i);
    end
  end

  assign emit    = (state_q == ST_EMIT);
  assign is_last = ($countones(rem_q) == 1);

  // NOTE: every variable assigned in this block gets a default value first.
  // As a result, no path leaves a variable unassigned, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (group_valid_i) begin
          if (flush_i || (slot_mask_i == '0)) begin
            // Empty or flushed group: drop the head without presenting it.
            pop_raw = 1'b1;
          end else begin
            rem_d   = slot_mask_i;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (flush_i) begin
          // Flush wins over a simultaneous handshake.
          pop_raw = 1'b1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (out_ready_i) begin
          rem_d[low_idx] = 1'b0;
          if (is_last) begin
            pop_raw = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        rem_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Blocking
  // assignments here would let flop order leak into simulation results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Reset gates pop_o. A group interrupted by reset stays at the FIFO head
  // and is rescheduled from slot 0 after reset is released.
  assign pop_o       = pop_raw && group_valid_i && !rst_i;
  assign out_valid_o = emit;
  assign sel_o       = emit ? low_idx : '0;
  assign last_o      = emit && is_last;

`ifdef MURE_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= 16'h0000;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mure_retire_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mure_retire_scheduler
//
// The main DUT has NRET=4. Its expected outputs come from a reference model
// that holds the current group as a queue of pending slot indices. A second
// DUT has NRET=2 and covers the reset-mid-group scenario directly.
// -----------------------------------------------------------------------------
module tb_mure_retire_scheduler;

  localparam int N = 4;
`ifdef MURE_SCHED_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NRET=4 instance
  logic         rst, gv, flush, ready;
  logic [N-1:0] mask;
  logic         pop, valid, last;
  logic [1:0]   sel;
  logic [15:0]  stall;

  // NRET=2 instance
  logic         rst_b, gv_b, flush_b, ready_b;
  logic [1:0]   mask_b;
  logic         pop_b, valid_b, last_b;
  logic [0:0]   sel_b;
  logic [15:0]  stall_b;

  mure_retire_scheduler #(.NRET(N)) dut (
    .clk_i(clk), .rst_i(rst), .group_valid_i(gv), .slot_mask_i(mask),
    .pop_o(pop), .flush_i(flush), .out_valid_o(valid), .out_ready_i(ready),
    .sel_o(sel), .last_o(last), .stall_cnt_o(stall)
  );

  mure_retire_scheduler #(.NRET(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .group_valid_i(gv_b), .slot_mask_i(mask_b),
    .pop_o(pop_b), .flush_i(flush_b), .out_valid_o(valid_b), .out_ready_i(ready_b),
    .sel_o(sel_b), .last_o(last_b), .stall_cnt_o(stall_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: busy flag, queue of slot indices still to present, and stall count.
  bit m_busy;
  int m_q[$];
  int m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge, with the inputs for this cycle already driven.
  task automatic cycle(input string tag);
    int e_sel;
    bit e_last, e_pop;
    #1;
    e_sel  = m_busy ? m_q[0] : 0;
    e_last = m_busy && (m_q.size() == 1);
    if (!m_busy) e_pop = gv && (flush || (mask == '0));
    else         e_pop = gv && (flush || (ready && m_q.size() == 1));
    check({tag, ".valid"}, valid, m_busy);
    check({tag, ".sel"},   sel,   e_sel);
    check({tag, ".last"},  last,  e_last);
    check({tag, ".pop"},   pop,   e_pop);
    check({tag, ".stall"}, stall, CNT_EN ? m_stall : 0);
    @(posedge clk);
    if (!m_busy) begin
      if (gv && !flush && (mask != '0)) begin
        for (int i = 0; i < N; i++) if (mask[i]) m_q.push_back(i);
        m_busy = 1'b1;
      end
    end else begin
      if (!ready && m_stall < 65535) m_stall++;
      if (flush) begin
        m_q.delete();
        m_busy = 1'b0;
      end else if (ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Called at a negedge. Checks the asynchronous effect of reset before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst.valid", valid, 0);
    check("rst.sel",   sel,   0);
    check("rst.last",  last,  0);
    check("rst.pop",   pop,   0);
    check("rst.stall", stall, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_busy  = 1'b0;
    m_q.delete();
    m_stall = 0;
  endtask

  initial begin
    rst = 1'b1; gv = 1'b0; mask = '0; ready = 1'b0; flush = 1'b0;
    rst_b = 1'b1; gv_b = 1'b0; mask_b = '0; ready_b = 1'b0; flush_b = 1'b0;
    m_busy = 1'b0; m_stall = 0;
    @(negedge clk);
    gv = 1'b1;  // pop must stay low during reset even with an empty head group
    do_reset();
    rst_b = 1'b0;
    gv = 1'b0;
    cycle("idle0");

    // Mask 1011, always ready: slots 0,1,3 presented, then pop on slot 3.
    // The mask input changes during EMIT and must be ignored.
    gv = 1'b1; mask = 4'b1011; ready = 1'b1;
    cycle("g1011.lat");
    mask = 4'b0100;
    repeat (3) cycle("g1011");
    gv = 1'b0;
    cycle("g1011.end");

    // Empty group: pop in the same cycle, nothing presented.
    gv = 1'b1; mask = 4'b0000;
    cycle("empty");
    gv = 1'b0;
    cycle("empty.end");

    // Mask 0110: stall 3 cycles on slot 1, then slots 1 and 2.
    do_reset();
    gv = 1'b1; mask = 4'b0110; ready = 1'b1;
    cycle("g0110.lat");
    ready = 1'b0;
    repeat (3) cycle("g0110.stall");
    ready = 1'b1;
    repeat (2) cycle("g0110");
    gv = 1'b0;
    cycle("g0110.end");
    check("g0110.stall_total", stall, CNT_EN ? 3 : 0);

    // Mask 1111: flush together with the handshake on slot 2.
    gv = 1'b1; mask = 4'b1111; ready = 1'b1;
    repeat (3) cycle("g1111");
    flush = 1'b1;
    cycle("g1111.flush");
    flush = 1'b0; gv = 1'b0;
    repeat (2) cycle("g1111.after");

    // Flush in IDLE: no effect without a group; with a group, pop and present nothing.
    flush = 1'b1;
    cycle("iflush.nogrp");
    gv = 1'b1; mask = 4'b0101;
    cycle("iflush.grp");
    flush = 1'b0; gv = 1'b0;
    cycle("iflush.end");

    // NRET=2: reset pulse after the slot 0 handshake, then restart from slot 0.
    gv_b = 1'b1; mask_b = 2'b11; ready_b = 1'b1;
    #1;
    check("b.idle.valid", valid_b, 0);
    check("b.idle.pop",   pop_b,   0);
    @(posedge clk); @(negedge clk); #1;
    check("b.s0.valid", valid_b, 1);
    check("b.s0.sel",   sel_b,   0);
    check("b.s0.last",  last_b,  0);
    @(posedge clk); @(negedge clk); #1;
    check("b.s1.sel",   sel_b,   1);
    check("b.s1.last",  last_b,  1);
    #1 rst_b = 1'b1;
    #1;
    check("b.rst.valid", valid_b, 0);
    check("b.rst.sel",   sel_b,   0);
    check("b.rst.last",  last_b,  0);
    check("b.rst.pop",   pop_b,   0);
    @(posedge clk); @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("b.rel.valid", valid_b, 0);
    check("b.rel.pop",   pop_b,   0);
    @(posedge clk); @(negedge clk); #1;
    check("b.re0.valid", valid_b, 1);
    check("b.re0.sel",   sel_b,   0);
    @(posedge clk); @(negedge clk); #1;
    check("b.re1.sel",   sel_b,   1);
    check("b.re1.pop",   pop_b,   1);
    check("b.stall",     stall_b, 0);
    @(posedge clk); @(negedge clk);
    gv_b = 1'b0;
    #1;
    check("b.end.valid", valid_b, 0);
    @(negedge clk);

    // Randomised traffic with occasional resets.
    repeat (500) begin
      gv    = ($urandom_range(0, 7) != 0);
      mask  = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) do_reset();
      cycle("rand");
    end

    // Saturation of the stall counter.
    flush = 1'b0;
    do_reset();
    gv = 1'b1; mask = 4'b0001; ready = 1'b0;
    cycle("sat.lat");
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_stall = 65535;
    #1;
    check("sat.valid", valid, 1);
    check("sat.stall", stall, CNT_EN ? 16'hFFFF : 16'h0000);
    ready = 1'b1;
    cycle("sat.drain");
    gv = 1'b0;
    cycle("sat.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
